pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 160, width of the payload data field.
REQ-002 SHALL provide parameter CTRL_W, default 16, width of the control field; this field is forced to zero on bubbles.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have ports, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, synchronous, active-high
  flush  in  1  synchronous kill of all held entries
  in_valid  in  1  upstream entry present
  in_ready  out  1  block can accept an entry this cycle
  in_data  in  DATA_W  upstream payload
  in_ctrl  in  CTRL_W  upstream control bits
  out_valid  out  1  entry presented downstream
  out_ready  in  1  downstream accepts this cycle
  out_data  out  DATA_W  head payload
  out_ctrl  out  CTRL_W  head control bits, zero when out_valid=0
  occupancy  out  2  entries held (0..2)
  stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Function
REQ-005 SHALL accept an entry when in_valid && in_ready, and SHALL release the head when out_valid && out_ready.
REQ-006 SHALL deliver entries in order, with no loss or duplication.
REQ-007 SHALL present an accepted entry on out_valid exactly 1 cycle after acceptance when the block was empty.
REQ-008 SHALL drive out_ctrl to all-zero whenever out_valid=0.
REQ-009 SHALL hold out_data at its last value when empty.
REQ-010 SHALL track states EMPTY (occupancy 0), ONE (1) and FULL (2; reachable only when the skid buffer is compiled in).
REQ-011 SHALL make these transitions: EMPTY+push->ONE; ONE+push, no pop->FULL; ONE+push+pop->ONE with new head; ONE+pop->EMPTY; FULL+pop->ONE with the skid entry promoted to head; all other cases hold.
REQ-012 SHALL give flush priority over push and pop: the next cycle has occupancy=0 and out_valid=0, and an entry offered in the flush cycle is dropped.
REQ-013 SHALL NOT clear stall_cnt on flush.
REQ-014 SHALL increment stall_cnt by 1 on each cycle with out_valid && !out_ready, and SHALL hold it at 2^CNT_W-1 once it saturates.
REQ-015 SHALL keep out_valid, out_data and out_ctrl stable while out_valid=1 and out_ready=0.

Reset
REQ-016 SHALL, while rst=1, drive at the next edge: occupancy=0, out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
REQ-017 SHALL hold in_ready=0 while rst=1.
REQ-018 SHALL give rst priority over flush and all handshakes, and SHALL discard all held entries if rst is asserted mid-transfer.

Configuration
REQ-019 SHALL use macro PIPE_SKID_REG_SKID_EN to select the buffering scheme.
REQ-020 SHALL, with PIPE_SKID_REG_SKID_EN defined, implement a 2-entry skid buffer whose in_ready is a register output equal to (occupancy != 2), with no combinational path from out_ready to in_ready.
REQ-021 SHALL, without PIPE_SKID_REG_SKID_EN, implement a single register with in_ready = !rst && (!out_valid || out_ready) combinationally; in this mode occupancy never exceeds 1, and a full-throughput push+pop SHALL be accepted in the same cycle.

Verification
REQ-022 SHALL cover: after reset, push 0xA5 with ctrl 0x0003, out_ready=1 -> out_valid=1 one cycle later with out_data=0xA5 and out_ctrl=0x0003, then out_valid=0 with out_ctrl=0.
REQ-023 SHALL cover (SKID_EN): out_ready=0 while pushing D1, D2, D3 on consecutive cycles -> occupancy=2, in_ready=0, D3 not accepted until re-offered; with out_ready=1, outputs are D1 then D2 then D3, in order.
REQ-024 SHALL cover: continuous in_valid=1 and out_ready=1 for 10 entries -> one entry out per cycle, stall_cnt stays 0.
REQ-025 SHALL cover: flush asserted with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, offered entry never appears.
REQ-026 SHALL cover: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and held there.
REQ-027 SHALL cover: rst asserted with occupancy=1 mid-stall -> next cycle all outputs zero, in_ready=0 until rst deasserts, then in_ready=1.

Source files
------------

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Purpose  : Valid/ready pipeline register with an optional 2-entry skid
//            buffer (define PIPE_SKID_REG_SKID_EN), flush, and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0]       c_st_empty = 2'd0;
    localparam logic [1:0]       c_st_one   = 2'd1;
    localparam logic [1:0]       c_st_full  = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [1:0]        r_state_q;
    logic [1:0]        w_state_d;
    logic [DATA_W-1:0] r_head_data_q;
    logic [DATA_W-1:0] w_head_data_d;
    logic [CTRL_W-1:0] r_head_ctrl_q;
    logic [CTRL_W-1:0] w_head_ctrl_d;
    logic [CNT_W-1:0]  r_stall_cnt_q;
    logic [CNT_W-1:0]  w_stall_cnt_d;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    assign w_valid = (r_state_q != c_st_empty);
    assign w_push  = in_valid && in_ready;
    assign w_pop   = w_valid && out_ready;

`ifdef PIPE_SKID_REG_SKID_EN
    logic [DATA_W-1:0] r_skid_data_q;
    logic [DATA_W-1:0] w_skid_data_d;
    logic [CTRL_W-1:0] r_skid_ctrl_q;
    logic [CTRL_W-1:0] w_skid_ctrl_d;
    logic              r_not_full_q;
    logic              w_not_full_d;

    // Registered ready: out_ready never reaches in_ready combinationally.
    assign in_ready     = r_not_full_q && !rst;
    assign w_not_full_d = (w_state_d != c_st_full);
`else
    assign in_ready = !rst && (!w_valid || out_ready);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_st_empty;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        if (flush) begin
            w_state_d = c_st_empty;
        end else begin
            case (r_state_q)
                c_st_empty: if (w_push) w_state_d = c_st_one;
                c_st_one: begin
                    if (!w_push && w_pop) begin
                        w_state_d = c_st_empty;
                    end
`ifdef PIPE_SKID_REG_SKID_EN
                    else if (w_push && !w_pop) begin
                        w_state_d = c_st_full;
                    end
`endif
                end
                c_st_full:  if (w_pop) w_state_d = c_st_one;
                default:    w_state_d = c_st_empty;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid = w_valid;
        occupancy = r_state_q;
        out_data  = r_head_data_q;
        out_ctrl  = w_valid ? r_head_ctrl_q : '0;
        stall_cnt = r_stall_cnt_q;
    end

    // Datapath: head reloads from input when empty or when popped in the same cycle
    always_comb begin
        w_head_data_d = r_head_data_q;
        w_head_ctrl_d = r_head_ctrl_q;
`ifdef PIPE_SKID_REG_SKID_EN
        w_skid_data_d = r_skid_data_q;
        w_skid_ctrl_d = r_skid_ctrl_q;
`endif
        if (!flush) begin
            if (w_push && ((r_state_q == c_st_empty) || w_pop)) begin
                w_head_data_d = in_data;
                w_head_ctrl_d = in_ctrl;
            end
`ifdef PIPE_SKID_REG_SKID_EN
            if ((r_state_q == c_st_full) && w_pop) begin
                w_head_data_d = r_skid_data_q;
                w_head_ctrl_d = r_skid_ctrl_q;
            end
            if (w_push && (r_state_q == c_st_one) && !w_pop) begin
                w_skid_data_d = in_data;
                w_skid_ctrl_d = in_ctrl;
            end
`endif
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_valid && !out_ready && (r_stall_cnt_q != c_cnt_max)) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_data_q <= '0;
            r_head_ctrl_q <= '0;
            r_stall_cnt_q <= '0;
`ifdef PIPE_SKID_REG_SKID_EN
            r_skid_data_q <= '0;
            r_skid_ctrl_q <= '0;
            r_not_full_q  <= 1'b1;
`endif
        end else begin
            r_head_data_q <= w_head_data_d;
            r_head_ctrl_q <= w_head_ctrl_d;
            r_stall_cnt_q <= w_stall_cnt_d;
`ifdef PIPE_SKID_REG_SKID_EN
            r_skid_data_q <= w_skid_data_d;
            r_skid_ctrl_q <= w_skid_ctrl_d;
            r_not_full_q  <= w_not_full_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Purpose  : Self-checking bench for pipe_skid_reg (either buffering scheme,
//            selected by PIPE_SKID_REG_SKID_EN), scoreboard-based ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int DW = 160;
    localparam int CW = 16;
    localparam int NW = 4;
`ifdef PIPE_SKID_REG_SKID_EN
    localparam logic [1:0] c_max_occ = 2'd2;
`else
    localparam logic [1:0] c_max_occ = 2'd1;
`endif

    typedef logic [DW+CW-1:0] entry_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    entry_t exp_q[$];
    entry_t want_q[$];
    entry_t got_q[$];
    int     vectors     = 0;
    int     miscompares = 0;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int i);
        logic [31:0] w;
        w = 32'hD00D_0000 | i[31:0];
        return {5{w}};
    endfunction

    // One clock: record handshakes just before the edge, return 1 time unit after it.
    task automatic tick();
        entry_t w;
        #1;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) w = exp_q.pop_front();
                else                  w = 'x;
                want_q.push_back(w);
                got_q.push_back({out_data, out_ctrl});
            end
            if (in_valid && in_ready) exp_q.push_back({in_data, in_ctrl});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        tick(); tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== '0 || out_ctrl !== '0) begin miscompares++; $display("FAIL reset_data: got %0h/%0h want 0/0", out_data, out_ctrl); end
        vectors++; if (stall_cnt !== '0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = DW'(8'hA5); in_ctrl = 16'h0003; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== DW'(8'hA5) || out_ctrl !== 16'h0003) begin miscompares++; $display("FAIL single_head: got %0h/%0h want a5/3", out_data, out_ctrl); end
        tick();
        vectors++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin miscompares++; $display("FAIL single_drain: got valid %b ctrl %0h want 0/0", out_valid, out_ctrl); end
        vectors++; if (out_data !== DW'(8'hA5)) begin miscompares++; $display("FAIL single_hold: got %0h want a5", out_data); end
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            entry_t g, w;
            g = got_q.pop_front(); w = want_q.pop_front();
            vectors++; if (g !== w) begin miscompares++; $display("FAIL single_sb: got %0h want %0h", g, w); end
        end
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = mk(i); in_ctrl = 16'h0100 + 16'(i);
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== mk(i)) begin miscompares++; $display("FAIL b2b_head%0d: got %b/%0h want 1/%0h", i, out_valid, out_data, mk(i)); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
        vectors++; if (stall_cnt !== '0) begin miscompares++; $display("FAIL b2b_stall: got %0d want 0", stall_cnt); end
        vectors++; if (got_q.size() != 10) begin miscompares++; $display("FAIL b2b_count: got %0d want 10", got_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            entry_t g, w;
            g = got_q.pop_front(); w = want_q.pop_front();
            vectors++; if (g !== w) begin miscompares++; $display("FAIL b2b_sb: got %0h want %0h", g, w); end
        end
        got_q.delete(); want_q.delete();
    endtask

    // Leaves the block stalled with one entry at the head for test_flush.
    task automatic test_stall_sat();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(50); in_ctrl = 16'h0050;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== mk(50) || out_ctrl !== 16'h0050) begin miscompares++; $display("FAIL stall_stable%0d: got %b/%0h/%0h", k, out_valid, out_data, out_ctrl); end
            if (k == 5) begin
                vectors++; if (stall_cnt !== 4'd5) begin miscompares++; $display("FAIL stall_count5: got %0d want 5", stall_cnt); end
            end
            if (k >= 20) begin
                vectors++; if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL stall_sat%0d: got %0d want 15", k, stall_cnt); end
            end
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = mk(60); in_ctrl = 16'h0060;
        tick();
        vectors++; if (occupancy !== c_max_occ || in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_fill: got occ %0d ready %b want %0d/0", occupancy, in_ready, c_max_occ); end
        flush = 1'b1; in_data = mk(70); in_ctrl = 16'h0070;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0) begin miscompares++; $display("FAIL flush_clear: got occ %0d valid %b ctrl %0h want 0/0/0", occupancy, out_valid, out_ctrl); end
        vectors++; if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL flush_stall_kept: got %0d want 15", stall_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ghost%0d: got %b want 0", k, out_valid); end
        end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", got_q.size()); end
        got_q.delete(); want_q.delete();
    endtask

`ifdef PIPE_SKID_REG_SKID_EN
    task automatic test_skid();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = mk(i); in_ctrl = 16'(i);
            tick();
        end
        tick();
        vectors++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_full: got occ %0d ready %b want 2/0", occupancy, in_ready); end
        vectors++; if (out_data !== mk(1)) begin miscompares++; $display("FAIL skid_head1: got %0h want %0h", out_data, mk(1)); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready_reg: got %b want 0", in_ready); end
        tick();
        vectors++; if (out_data !== mk(2) || occupancy !== 2'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_head2: got %0h occ %0d ready %b", out_data, occupancy, in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== mk(3)) begin miscompares++; $display("FAIL skid_head3: got %b/%0h want 1/%0h", out_valid, out_data, mk(3)); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty: got %b want 0", out_valid); end
        vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL skid_count: got %0d want 3", got_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            entry_t g, w;
            g = got_q.pop_front(); w = want_q.pop_front();
            vectors++; if (g !== w) begin miscompares++; $display("FAIL skid_sb: got %0h want %0h", g, w); end
        end
        got_q.delete(); want_q.delete();
    endtask
`else
    task automatic test_passthrough();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(1); in_ctrl = 16'h0001;
        tick();
        in_data = mk(2); in_ctrl = 16'h0002;
        #1;
        vectors++; if (in_ready !== 1'b0 || occupancy !== 2'd1) begin miscompares++; $display("FAIL pass_block: got ready %b occ %0d want 0/1", in_ready, occupancy); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL pass_comb_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_data !== mk(2) || occupancy !== 2'd1) begin miscompares++; $display("FAIL pass_swap: got %0h occ %0d want %0h/1", out_data, occupancy, mk(2)); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pass_empty: got %b want 0", out_valid); end
        vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL pass_count: got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            entry_t g, w;
            g = got_q.pop_front(); w = want_q.pop_front();
            vectors++; if (g !== w) begin miscompares++; $display("FAIL pass_sb: got %0h want %0h", g, w); end
        end
        got_q.delete(); want_q.delete();
    endtask
`endif

    task automatic test_rst_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(80); in_ctrl = 16'h0080;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (occupancy !== 2'd1 || stall_cnt === '0) begin miscompares++; $display("FAIL rstmid_pre: got occ %0d stall %0d want 1/nonzero", occupancy, stall_cnt); end
        rst = 1'b1; in_valid = 1'b1; in_data = mk(81); in_ctrl = 16'h0081; out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_now: got %b want 0", in_ready); end
        tick();
        vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || stall_cnt !== '0) begin miscompares++; $display("FAIL rstmid_zero: got occ %0d valid %b data %0h ctrl %0h stall %0d", occupancy, out_valid, out_data, out_ctrl, stall_cnt); end
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_hold: got %b want 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready_rel: got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_ghost%0d: got %b want 0", k, out_valid); end
        end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_sat();
        test_flush();
`ifdef PIPE_SKID_REG_SKID_EN
        test_skid();
`else
        test_passthrough();
`endif
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
